adc_scan_sequencer: RTL and testbench

//  Sequences the ADC analog front end. Walks the enabled AMUX channels in ascending order: select, settle, trigger, wait for conversion, capture result.

---
 rtl/adc_seq_pkg.sv | 20 ++
 rtl/adc_chan_picker.sv | 27 ++
 rtl/adc_scan_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared types and default sizing for the ADC scan sequencer.
package adc_seq_pkg;

  localparam int unsigned NUM_CH_DEF   = 8;
  localparam int unsigned CH_W_DEF     = $clog2(NUM_CH_DEF);
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned SETTLE_W_DEF = 8;
  localparam int unsigned TIMEOUT_DEF  = 255;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_SETTLE  = 3'd2,
    S_TRIGGER = 3'd3,
    S_WAIT    = 3'd4,
    S_STORE   = 3'd5,
    S_NEXT    = 3'd6
  } state_t;

endpackage

// File: rtl/adc_chan_picker.sv
// Priority finder: lowest set mask bit, either from channel 0 or strictly above cur_ch.
module adc_chan_picker
  import adc_seq_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned CH_W   = CH_W_DEF
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur_ch,
  input  logic              from_start,
  output logic [CH_W-1:0]   next_ch,
  output logic              found
);

  // Scan downward so the lowest qualifying bit is the one left standing.
  always_comb begin
    next_ch = '0;
    found   = 1'b0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(cur_ch)))) begin
        next_ch = CH_W'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Walks enabled AMUX channels: select, settle, trigger, wait, store; single-shot or continuous.
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned NUM_CH     = NUM_CH_DEF,
  parameter int unsigned CH_W       = CH_W_DEF,
  parameter int unsigned DATA_WIDTH = DATA_W_DEF,
  parameter int unsigned SETTLE_W   = SETTLE_W_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  scan_start,
  input  logic                  continuous,
  input  logic [NUM_CH-1:0]     chan_mask,
  input  logic [SETTLE_W-1:0]   settle_cycles,
  output logic [CH_W-1:0]       amux_sel,
  output logic                  adc_trigger,
  input  logic                  adc_done,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output logic                  res_valid,
  output logic [CH_W-1:0]       res_chan,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  busy,
  output logic                  scan_done,
  output logic                  timeout_err
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W = (SETTLE_W > TO_W) ? SETTLE_W : TO_W;

  state_t                state_q, state_d;
  logic [NUM_CH-1:0]     mask_q, mask_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CH_W-1:0]       cur_q, cur_d;

  logic [CH_W-1:0]       amux_d;
  logic                  trig_d;
  logic                  rv_d;
  logic [CH_W-1:0]       rch_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  busy_d;
  logic                  sdone_d;
  logic                  terr_d;

  logic [CH_W-1:0]       start_ch;
  logic                  start_found;
  logic [CH_W-1:0]       hi_ch;
  logic                  hi_found;

  // Lowest enabled channel of the live mask, for scan start and continuous reload.
  adc_chan_picker #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_start_pick (
    .mask       (chan_mask),
    .cur_ch     (cur_q),
    .from_start (1'b1),
    .next_ch    (start_ch),
    .found      (start_found)
  );

  // Next enabled channel above the current one within the latched pass mask.
  adc_chan_picker #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_next_pick (
    .mask       (mask_q),
    .cur_ch     (cur_q),
    .from_start (1'b0),
    .next_ch    (hi_ch),
    .found      (hi_found)
  );

  // Next-state and next-output logic; outputs are decoded from the upcoming state and registered.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    cur_d    = cur_q;
    amux_d   = amux_sel;
    trig_d   = 1'b0;
    rv_d     = 1'b0;
    rch_d    = res_chan;
    rdata_d  = res_data;
    sdone_d  = 1'b0;
    terr_d   = timeout_err;

    case (state_q)
      S_IDLE: begin
        if (scan_start && start_found) begin
          state_d  = S_SELECT;
          mask_d   = chan_mask;
          settle_d = settle_cycles;
          cur_d    = start_ch;
          amux_d   = start_ch;
          terr_d   = 1'b0;
        end
      end
      S_SELECT: begin
        cnt_d = '0;
        if (settle_q == '0) begin
          state_d = S_TRIGGER;
          trig_d  = 1'b1;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_W'(settle_q) - CNT_W'(1)) begin
          state_d = S_TRIGGER;
          trig_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_TRIGGER: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // A done arriving on the last allowed cycle still counts as a result.
        if (adc_done) begin
          state_d = S_STORE;
          rv_d    = 1'b1;
          rch_d   = cur_q;
          rdata_d = adc_data;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_NEXT;
          terr_d  = 1'b1;
          sdone_d = !hi_found;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STORE: begin
        state_d = S_NEXT;
        sdone_d = !hi_found;
      end
      S_NEXT: begin
        if (hi_found) begin
          state_d = S_SELECT;
          cur_d   = hi_ch;
          amux_d  = hi_ch;
        end else if (continuous && start_found) begin
          state_d  = S_SELECT;
          mask_d   = chan_mask;
          settle_d = settle_cycles;
          cur_d    = start_ch;
          amux_d   = start_ch;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      settle_q    <= '0;
      cnt_q       <= '0;
      cur_q       <= '0;
      amux_sel    <= '0;
      adc_trigger <= 1'b0;
      res_valid   <= 1'b0;
      res_chan    <= '0;
      res_data    <= '0;
      busy        <= 1'b0;
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      settle_q    <= settle_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      amux_sel    <= amux_d;
      adc_trigger <= trig_d;
      res_valid   <= rv_d;
      res_chan    <= rch_d;
      res_data    <= rdata_d;
      busy        <= busy_d;
      scan_done   <= sdone_d;
      timeout_err <= terr_d;
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Plans a stimulus timeline and the expected per-cycle outputs from channel-level timing rules,
// then drives the DUT and compares every planned cycle.
module tb_adc_scan_sequencer;

  localparam int TO   = 255;
  localparam int MAXC = 60000;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        scan_start;
  logic        continuous;
  logic [7:0]  chan_mask;
  logic [7:0]  settle_cycles;
  logic [2:0]  amux_sel;
  logic        adc_trigger;
  logic        adc_done;
  logic [31:0] adc_data;
  logic        res_valid;
  logic [2:0]  res_chan;
  logic [31:0] res_data;
  logic        busy;
  logic        scan_done;
  logic        timeout_err;

  adc_scan_sequencer dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .scan_start    (scan_start),
    .continuous    (continuous),
    .chan_mask     (chan_mask),
    .settle_cycles (settle_cycles),
    .amux_sel      (amux_sel),
    .adc_trigger   (adc_trigger),
    .adc_done      (adc_done),
    .adc_data      (adc_data),
    .res_valid     (res_valid),
    .res_chan      (res_chan),
    .res_data      (res_data),
    .busy          (busy),
    .scan_done     (scan_done),
    .timeout_err   (timeout_err)
  );

  always #5 PCLK = ~PCLK;

  // Stimulus timeline
  bit          d_rst   [MAXC];
  bit          d_start [MAXC];
  bit          d_cont  [MAXC];
  logic [7:0]  d_mask  [MAXC];
  logic [7:0]  d_settle[MAXC];
  bit          d_done  [MAXC];
  logic [31:0] d_data  [MAXC];

  // Expected outputs per cycle
  bit          e_chk  [MAXC];
  logic [2:0]  e_amux [MAXC];
  bit          e_trig [MAXC];
  bit          e_rv   [MAXC];
  logic [2:0]  e_rch  [MAXC];
  logic [31:0] e_rdata[MAXC];
  bit          e_busy [MAXC];
  bit          e_sdone[MAXC];
  bit          e_terr [MAXC];

  // Values the outputs hold between events
  logic [2:0]  h_amux  = '0;
  logic [2:0]  h_rch   = '0;
  logic [31:0] h_rdata = '0;
  bit          h_terr  = 1'b0;
  int          pc;

  typedef struct { int cyc; int sig; logic [31:0] val; } pin_t;
  pin_t pins[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit run    = 1'b0;

  function automatic void add_pin(input int c, input int s, input logic [31:0] v);
    pin_t p;
    p.cyc = c; p.sig = s; p.val = v;
    pins.push_back(p);
  endfunction

  // One planned cycle: held values, no pulses; don't-care inputs randomised.
  task automatic put(input int c, input bit bsy, input bit in_wait);
    e_chk[c]   = 1'b1;
    e_amux[c]  = h_amux;
    e_rch[c]   = h_rch;
    e_rdata[c] = h_rdata;
    e_terr[c]  = h_terr;
    e_busy[c]  = bsy;
    e_trig[c]  = 1'b0;
    e_rv[c]    = 1'b0;
    e_sdone[c] = 1'b0;
    d_rst[c]    = 1'b0;
    d_start[c]  = bsy ? ($urandom_range(0, 5) == 0) : 1'b0;
    d_mask[c]   = 8'($urandom);
    d_settle[c] = 8'($urandom);
    d_cont[c]   = 1'($urandom);
    d_done[c]   = in_wait ? 1'b0 : ($urandom_range(0, 4) == 0);
    d_data[c]   = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      put(pc, 1'b0, 1'b0);
      pc++;
    end
  endtask

  task automatic idle_start_zero();
    put(pc, 1'b0, 1'b0);
    d_start[pc] = 1'b1;
    d_mask[pc]  = 8'h00;
    pc++;
  endtask

  // Latency from trigger to done: >0 fixed, <0 never, 0 random (0 returned = no done).
  function automatic int pick_lat(input int lat);
    int r;
    if (lat > 0) return lat;
    if (lat < 0) return 0;
    r = $urandom_range(0, 39);
    if (r == 0) return 0;
    if (r < 3) return $urandom_range(250, 255);
    return $urandom_range(1, 8);
  endfunction

  // Plan one scan: start, passes over the mask, optional reset after abort_w WAIT cycles.
  task automatic do_scan(input logic [7:0] mask0, input int settle0, input int passes,
                         input int lat, input bit vary, input int abort_w);
    logic [7:0] m, nm;
    int n, ns, t, d;
    put(pc, 1'b0, 1'b0);
    d_start[pc]  = 1'b1;
    d_mask[pc]   = mask0;
    d_settle[pc] = 8'(settle0);
    pc++;
    m = mask0; n = settle0; t = pc; h_terr = 1'b0;
    nm = m; ns = n;
    for (int p = 0; p < passes; p++) begin
      for (int ch = 0; ch < 8; ch++) begin
        if (m[ch]) begin
          h_amux = 3'(ch);
          put(t, 1'b1, 1'b0);
          for (int s = 1; s <= n; s++) put(t + s, 1'b1, 1'b0);
          put(t + n + 1, 1'b1, 1'b0);
          e_trig[t + n + 1] = 1'b1;
          if (abort_w > 0) begin
            for (int w = 1; w <= abort_w; w++) put(t + n + 1 + w, 1'b1, 1'b1);
            d_rst[t + n + 1 + abort_w] = 1'b1;
            h_amux = '0; h_rch = '0; h_rdata = '0; h_terr = 1'b0;
            pc = t + n + 2 + abort_w;
            put(pc, 1'b0, 1'b0);
            d_done[pc] = 1'b1;
            pc++;
            put(pc, 1'b0, 1'b0);
            d_done[pc] = 1'b1;
            pc++;
            return;
          end
          d = pick_lat(lat);
          if (d > 0) begin
            for (int w = 1; w <= d; w++) put(t + n + 1 + w, 1'b1, 1'b1);
            d_done[t + n + 1 + d] = 1'b1;
            h_rch   = 3'(ch);
            h_rdata = d_data[t + n + 1 + d];
            put(t + n + 2 + d, 1'b1, 1'b0);
            e_rv[t + n + 2 + d] = 1'b1;
            t = t + n + 3 + d;
          end else begin
            for (int w = 1; w <= TO; w++) put(t + n + 1 + w, 1'b1, 1'b1);
            h_terr = 1'b1;
            t = t + n + 2 + TO;
          end
          put(t, 1'b1, 1'b0);
          if ((m >> (ch + 1)) == 8'd0) begin
            e_sdone[t] = 1'b1;
            if (p < passes - 1) begin
              nm = vary ? 8'($urandom_range(1, 255)) : m;
              ns = vary ? $urandom_range(0, 4) : n;
              d_cont[t]   = 1'b1;
              d_mask[t]   = nm;
              d_settle[t] = 8'(ns);
            end else if ($urandom_range(0, 1) == 0) begin
              d_cont[t] = 1'b0;
            end else begin
              d_cont[t] = 1'b1;
              d_mask[t] = 8'h00;
            end
          end
          t = t + 1;
        end
      end
      m = nm; n = ns;
    end
    pc = t;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] pin_act(input int s);
    case (s)
      0: return 32'(adc_trigger);
      1: return 32'(res_valid);
      2: return 32'(res_chan);
      3: return 32'(scan_done);
      4: return 32'(busy);
      5: return 32'(timeout_err);
      default: return 32'(amux_sel);
    endcase
  endfunction

  function automatic string pin_name(input int s);
    case (s)
      0: return "pin_adc_trigger";
      1: return "pin_res_valid";
      2: return "pin_res_chan";
      3: return "pin_scan_done";
      4: return "pin_busy";
      5: return "pin_timeout_err";
      default: return "pin_amux_sel";
    endcase
  endfunction

  // Compare process: model expectations every planned cycle, plus literal pins.
  always @(negedge PCLK) begin
    if (run && e_chk[cyc]) begin
      chk("amux_sel",    32'(amux_sel),    32'(e_amux[cyc]));
      chk("adc_trigger", 32'(adc_trigger), 32'(e_trig[cyc]));
      chk("res_valid",   32'(res_valid),   32'(e_rv[cyc]));
      chk("res_chan",    32'(res_chan),    32'(e_rch[cyc]));
      chk("res_data",    res_data,         e_rdata[cyc]);
      chk("busy",        32'(busy),        32'(e_busy[cyc]));
      chk("scan_done",   32'(scan_done),   32'(e_sdone[cyc]));
      chk("timeout_err", 32'(timeout_err), 32'(e_terr[cyc]));
      foreach (pins[i]) begin
        if (pins[i].cyc == cyc) chk(pin_name(pins[i].sig), pin_act(pins[i].sig), pins[i].val);
      end
    end
  end

  initial begin
    int s, ncyc;
    // Reset
    put(0, 1'b0, 1'b0); e_chk[0] = 1'b0; d_rst[0] = 1'b1;
    put(1, 1'b0, 1'b0); d_rst[1] = 1'b1;
    pc = 2;
    idle(2);

    // Two-channel single shot, settle 2, done 3 cycles after trigger
    s = pc;
    do_scan(8'h05, 2, 1, 3, 1'b0, 0);
    add_pin(s + 1, 6, 0);  add_pin(s + 3, 0, 0);  add_pin(s + 4, 0, 1);
    add_pin(s + 8, 1, 1);  add_pin(s + 8, 2, 0);  add_pin(s + 10, 6, 2);
    add_pin(s + 17, 1, 1); add_pin(s + 17, 2, 2); add_pin(s + 18, 3, 1);
    add_pin(s + 18, 4, 1); add_pin(s + 19, 4, 0);
    idle(3);

    // Start with an empty mask is ignored
    for (int i = 0; i < 3; i++) begin
      add_pin(pc + 1, 4, 0);
      idle_start_zero();
    end
    idle(2);

    // Timeout on channel 7, then a fresh start clears the sticky error
    s = pc;
    do_scan(8'h80, 1, 1, -1, 1'b0, 0);
    add_pin(s + 1, 6, 7);   add_pin(s + 258, 5, 0); add_pin(s + 259, 5, 1);
    add_pin(s + 259, 3, 1); add_pin(s + 260, 4, 0);
    idle(2);
    s = pc;
    do_scan(8'h01, 0, 1, 2, 1'b0, 0);
    add_pin(s, 5, 1); add_pin(s + 1, 5, 0); add_pin(s + 2, 0, 1);
    idle(2);

    // Continuous, three passes over ch0/ch1
    s = pc;
    do_scan(8'h03, 1, 3, 2, 1'b0, 0);
    add_pin(s + 20, 1, 1); add_pin(s + 20, 2, 0); add_pin(s + 27, 2, 1);
    add_pin(s + 28, 3, 1); add_pin(s + 42, 3, 1); add_pin(s + 43, 4, 0);
    idle(2);

    // Reset during WAIT
    s = pc;
    do_scan(8'h0C, 1, 1, 0, 1'b0, 3);
    add_pin(s + 6, 6, 2); add_pin(s + 7, 6, 0); add_pin(s + 7, 4, 0); add_pin(s + 8, 1, 0);
    idle(3);

    // Done on the last allowed WAIT cycle, with stray pulses while busy
    s = pc;
    do_scan(8'h12, 0, 1, 255, 1'b0, 0);
    d_done[s + 1] = 1'b1; d_done[s + 2] = 1'b1;
    d_start[s + 1] = 1'b1; d_start[s + 5] = 1'b1;
    add_pin(s + 258, 1, 1); add_pin(s + 258, 2, 1); add_pin(s + 258, 5, 0);
    idle(2);

    // Randomised scans
    for (int i = 0; i < 40 && pc < MAXC - 8000; i++) begin
      if ($urandom_range(0, 7) == 0) idle_start_zero();
      do_scan(8'($urandom_range(1, 255)),
              ($urandom_range(0, 5) == 0) ? $urandom_range(5, 30) : $urandom_range(0, 4),
              $urandom_range(1, 3), 0, 1'b1,
              ($urandom_range(0, 9) == 0) ? $urandom_range(1, 5) : 0);
      idle($urandom_range(0, 3));
    end
    idle(2);
    ncyc = pc;

    run = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      PRESET        = d_rst[c];
      scan_start    = d_start[c];
      continuous    = d_cont[c];
      chan_mask     = d_mask[c];
      settle_cycles = d_settle[c];
      adc_done      = d_done[c];
      adc_data      = d_data[c];
      cyc           = c;
      @(posedge PCLK);
      #1;
    end
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
